sinx_stream_frontend: RTL and testbench
=======================================

Name: sinx_stream_frontend

Overview:
- Streaming front-end that sits directly upstream of the sin(x) engine, i.e. the controller plus its datapath.
- Accepts x samples on a valid/ready input and buffers them in a small FIFO.
- Issues one engine computation per sample and holds x stable for the engine's full run.
- Captures the engine result when done is signalled and presents it on a valid/ready output with backpressure.

Parameters:
- DATA_W, 16, width of x samples and sin results.
- FIFO_DEPTH, 4, input FIFO entries; must be a power of 2 and at least 2.
- TIMEOUT, 63, maximum number of WAIT cycles with eng_done_i low before error.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  asynchronous active-low reset.
- s_valid_i  in  1  input sample valid.
- s_ready_o  out  1  input ready; equals !fifo_full.
- s_data_i  in  DATA_W  input x sample.
- m_valid_o  out  1  result valid.
- m_ready_i  in  1  result accepted.
- m_data_o  out  DATA_W  sin(x) result.
- eng_start_o  out  1  one-cycle start pulse to the engine.
- eng_x_o  out  DATA_W  x operand to the engine, registered.
- eng_done_i  in  1  engine done level; high while the engine is in its DONE state.
- eng_result_i  in  DATA_W  engine sum output, valid while eng_done_i is high.
- busy_o  out  1  high when the FSM is not in IDLE.
- count_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, rstn_i low):
  - FSM goes to IDLE; FIFO is emptied.
  - Outputs: m_valid_o=0, m_data_o=0, eng_start_o=0, eng_x_o=0, busy_o=0, count_o=0, err_o=0, s_ready_o=1.
  - Reset mid-computation discards the in-flight sample and all buffered samples. The engine shares rstn_i.
- FIFO:
  - Push when s_valid_i & s_ready_o; pop when the FSM leaves IDLE.
  - Simultaneous push and pop leaves the count unchanged.
  - No pass-through when full: s_ready_o=0, so the sample is held upstream.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop from an empty FIFO never occurs.
- FSM states: IDLE, START, ARM, WAIT.
  - IDLE: if count_o>0, pop the head into eng_x_o and go to START; otherwise stay.
  - START: eng_start_o=1 for exactly this cycle, then go to ARM.
  - ARM: one cycle in which eng_done_i is ignored, because the engine may still be leaving DONE. Go to WAIT.
  - WAIT, done low: if eng_done_i=0, increment the timeout counter.
  - WAIT, timeout: when the counter reaches TIMEOUT, set err_o (sticky until reset), leave m_valid_o unchanged, drop the sample, and go to IDLE.
  - WAIT, done high with output free: if eng_done_i=1 and the output register is free (!m_valid_o | m_ready_i), load m_data_o<=eng_result_i, set m_valid_o<=1, and go to IDLE.
  - WAIT, done high with output occupied: stay in WAIT with the timeout counter frozen. The engine holds DONE and its result stable.
  - The timeout counter clears on entry to ARM.
- Output register:
  - m_valid_o clears on m_ready_i unless a new capture happens in the same cycle.
  - m_data_o is stable while m_valid_o & !m_ready_i.
- eng_x_o changes only on the IDLE pop; it is constant from START through WAIT exit.
- Timing with the production engine (8 iterations × 3 cycles + INIT):
  - Pop edge ends cycle t; eng_start_o is high in t+1; engine done is seen in t+27; m_valid_o rises at t+28.
  - Back-to-back samples: next eng_start_o at t+29, i.e. a 28-cycle issue interval.

Test Plan:
- Single sample: with the engine model (DONE 26 cycles after start, result = x ^ 16'hA5A5), push x=16'h1234 → eng_start_o pulses once, eng_x_o=16'h1234 held throughout, m_data_o=16'hB791, and m_valid_o rises 28 cycles after the pop.
- Fill to full: push 5 samples with no pop possible (engine busy) → count_o=4, s_ready_o=0, and the 5th sample is accepted only after the next IDLE pop.
- Backpressure: hold m_ready_i=0 across two results → the second computation stays in WAIT with err_o=0 and no timeout; releasing m_ready_i yields both results in order with no loss.
- Stale done: engine model holds eng_done_i=1 until 2 cycles after start → the ARM/WAIT timing still waits for the fresh done and returns the correct result, not the previous one.
- Timeout: engine model never asserts done → err_o=1 exactly TIMEOUT+1 cycles after WAIT entry, FSM returns to IDLE, and the next sample is still processed.
- Reset mid-WAIT: assert rstn_i low with 3 samples queued → all outputs go to reset values immediately; after release, count_o=0 and no m_valid_o appears.

Source files
------------

// File: rtl/sinx_stream_frontend.sv
// Streaming front-end for the sin(x) engine: input FIFO, start/arm/wait sequencing,
// timeout detection and a backpressured result register.
module sinx_stream_frontend #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 63
) (
  input  logic                                 clk_i,
  input  logic                                 rstn_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  input  logic [DATA_W-1:0]                    s_data_i,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i,
  output logic [DATA_W-1:0]                    m_data_o,
  output logic                                 eng_start_o,
  output logic [DATA_W-1:0]                    eng_x_o,
  input  logic                                 eng_done_i,
  input  logic [DATA_W-1:0]                    eng_result_i,
  output logic                                 busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      count_o,
  output logic                                 err_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, ARM, WAIT} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [TO_W-1:0]   to_cnt;
  logic              push;
  logic              pop;

  assign s_ready_o = (count_o != CNT_W'(FIFO_DEPTH));
  assign push      = s_valid_i & s_ready_o;
  assign pop       = (state == IDLE) & (count_o != '0);
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= s_data_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_o <= count_o + CNT_W'(1);
        2'b01:   count_o <= count_o - CNT_W'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      eng_start_o <= 1'b0;
      eng_x_o     <= '0;
      to_cnt      <= '0;
      err_o       <= 1'b0;
      m_valid_o   <= 1'b0;
      m_data_o    <= '0;
    end else begin
      eng_start_o <= 1'b0;
      if (m_ready_i) m_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            eng_x_o     <= mem[rd_ptr];
            eng_start_o <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= ARM;
        end
        // The engine may still be leaving DONE from the previous run, so done is ignored here.
        ARM: state <= WAIT;
        WAIT: begin
          if (eng_done_i) begin
            // With the output occupied we stall here; the counter stays frozen.
            if (!m_valid_o || m_ready_i) begin
              m_data_o  <= eng_result_i;
              m_valid_o <= 1'b1;
              state     <= IDLE;
            end
          end else if (to_cnt == TO_W'(TIMEOUT)) begin
            err_o <= 1'b1;
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sinx_stream_frontend.sv
// Scoreboard bench for sinx_stream_frontend with a behavioural engine model
// (done 26 cycles after start, result = x ^ 16'hA5A5).
module tb_sinx_stream_frontend;

  localparam int unsigned DW  = 16;
  localparam int unsigned FD  = 4;
  localparam int unsigned TMO = 63;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_data_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_data_o;
  logic          eng_start_o;
  logic [DW-1:0] eng_x_o;
  logic          eng_done;
  logic [DW-1:0] eng_res;
  logic          busy_o;
  logic [2:0]    count_o;
  logic          err_o;

  sinx_stream_frontend #(.DATA_W(DW), .FIFO_DEPTH(FD), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .eng_start_o(eng_start_o), .eng_x_o(eng_x_o),
    .eng_done_i(eng_done), .eng_result_i(eng_res),
    .busy_o(busy_o), .count_o(count_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned eng_mode = 0;    // 0 normal, 1 stale done, 2 never done
  int unsigned ready_mode = 2;  // 0 stall, 1 random, 2 always ready
  logic [DW-1:0] x_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_out = '0;
  int unsigned n_starts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic bad(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not as required (cycle %0d)", name, cyc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, 32'(m_valid_o), 32'd0);
    chk({tag, "_m_data"}, 32'(m_data_o), 32'd0);
    chk({tag, "_start"}, 32'(eng_start_o), 32'd0);
    chk({tag, "_eng_x"}, 32'(eng_x_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_count"}, 32'(count_o), 32'd0);
    chk({tag, "_err"}, 32'(err_o), 32'd0);
    chk({tag, "_s_ready"}, 32'(s_ready_o), 32'd1);
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Engine model: result appears 26 cycles after the start cycle and is held until the next start.
  int unsigned   eng_cnt;
  bit            eng_run;
  bit            eng_hold;
  logic [DW-1:0] eng_xl;
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      eng_done <= 1'b0; eng_res <= '0; eng_cnt <= 0;
      eng_run <= 1'b0; eng_hold <= 1'b0; eng_xl <= '0;
    end else if (eng_start_o) begin
      eng_xl  <= eng_x_o;
      eng_cnt <= 1;
      eng_run <= (eng_mode != 2);
      if (eng_mode == 1) eng_hold <= 1'b1;
      else eng_done <= 1'b0;
    end else begin
      if (eng_hold) begin
        eng_hold <= 1'b0;
        eng_done <= 1'b0;
      end
      if (eng_run) begin
        if (eng_cnt == 25) begin
          eng_done <= 1'b1;
          eng_res  <= eng_xl ^ 16'hA5A5;
          eng_run  <= 1'b0;
        end else begin
          eng_cnt <= eng_cnt + 1;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    case (ready_mode)
      2:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'($urandom_range(0, 1));
      default: m_ready_i = 1'b0;
    endcase
  end

  // Monitor: scoreboard pops and protocol/timing checks, sampled mid-cycle.
  bit            p_start, p_busy, p_valid, p_ready, p_err;
  logic [DW-1:0] p_x, p_data;
  int unsigned   start_cyc = 0;
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      p_start = 0; p_busy = 0; p_valid = 0; p_ready = 0; p_err = 0;
      p_x = '0; p_data = '0;
    end else begin
      chk("s_ready_vs_count", 32'(s_ready_o), 32'(count_o != 3'(FD)));
      if (eng_start_o) begin
        n_starts++;
        chk("start_width", 32'(p_start), 32'd0);
        if (x_q.size() == 0) bad("start_spurious");
        else chk("eng_x_at_start", 32'(eng_x_o), 32'(x_q.pop_front()));
        start_cyc = cyc;
      end
      if (busy_o && p_busy) chk("eng_x_hold", 32'(eng_x_o), 32'(p_x));
      if (m_valid_o && !p_valid) chk("result_latency", cyc - start_cyc, 32'd27);
      if (err_o && !p_err) chk("timeout_latency", cyc - start_cyc, 32'(TMO + 3));
      if (p_valid && !p_ready) begin
        chk("hold_valid", 32'(m_valid_o), 32'd1);
        chk("hold_data", 32'(m_data_o), 32'(p_data));
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) bad("out_spurious");
        else chk("out_data", 32'(m_data_o), 32'(exp_q.pop_front()));
        last_out = m_data_o;
      end
      p_start = eng_start_o; p_busy = busy_o; p_valid = m_valid_o;
      p_ready = m_ready_i; p_err = err_o; p_x = eng_x_o; p_data = m_data_o;
    end
  end

  // Called just after a rising edge; returns eng_start_o as seen in the acceptance cycle.
  task automatic push(input logic [DW-1:0] x, input bit keep, output bit st_at_acc);
    int unsigned k = 0;
    st_at_acc = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = x;
    @(negedge clk_i);
    while (!s_ready_o && k < 300) begin
      k++;
      @(negedge clk_i);
    end
    if (!s_ready_o) begin
      bad("push_accept_timeout");
    end else begin
      st_at_acc = eng_start_o;
      x_q.push_back(x);
      if (keep) exp_q.push_back(x ^ 16'hA5A5);
    end
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic drain();
    int unsigned k = 0;
    while ((exp_q.size() != 0 || busy_o || count_o != 0) && k < 3000) begin
      k++;
      @(negedge clk_i);
    end
    if (k >= 3000) bad("drain_timeout");
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bit st;
    int unsigned s0, k;
    rstn_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0; m_ready_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk_i);
    #1 rstn_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Single sample
    s0 = n_starts;
    push(16'h1234, 1'b1, st);
    drain();
    chk("single_result", 32'(last_out), 32'h0000B791);
    chk("single_start_count", n_starts - s0, 32'd1);

    // Fill to full while the engine is busy
    push(16'h0101, 1'b1, st);
    push(16'h0202, 1'b1, st);
    push(16'h0303, 1'b1, st);
    push(16'h0404, 1'b1, st);
    push(16'h0505, 1'b1, st);
    @(negedge clk_i);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_s_ready", 32'(s_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    push(16'h0606, 1'b1, st);
    chk("full_accept_after_pop", 32'(st), 32'd1);
    drain();

    // Backpressure across two results
    ready_mode = 0;
    push(16'h1111, 1'b1, st);
    push(16'h2222, 1'b1, st);
    repeat (150) @(posedge clk_i);
    @(negedge clk_i);
    chk("bp_err", 32'(err_o), 32'd0);
    chk("bp_busy", 32'(busy_o), 32'd1);
    chk("bp_valid", 32'(m_valid_o), 32'd1);
    chk("bp_data", 32'(m_data_o), 32'(16'h1111 ^ 16'hA5A5));
    @(posedge clk_i);
    #1 ready_mode = 2;
    drain();

    // Stale done from the previous run must not be captured
    eng_mode = 1;
    push(16'h5A5A, 1'b1, st);
    drain();
    chk("stale_result", 32'(last_out), 32'(16'h5A5A ^ 16'hA5A5));
    eng_mode = 0;

    // Randomised traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
      push(16'($urandom), 1'b1, st);
    end
    ready_mode = 2;
    drain();

    // Timeout: engine never finishes
    eng_mode = 2;
    push(16'hDEAD, 1'b0, st);
    k = 0;
    @(negedge clk_i);
    while (!err_o && k < 300) begin
      k++;
      @(negedge clk_i);
    end
    if (!err_o) bad("timeout_never_flagged");
    chk("timeout_idle", 32'(busy_o), 32'd0);
    chk("timeout_no_valid", 32'(m_valid_o), 32'd0);
    @(posedge clk_i);
    #1 eng_mode = 0;
    push(16'hBEEF, 1'b1, st);
    drain();
    chk("timeout_next_result", 32'(last_out), 32'(16'hBEEF ^ 16'hA5A5));
    chk("err_sticky", 32'(err_o), 32'd1);

    // Reset in WAIT with three samples buffered
    push(16'h7001, 1'b1, st);
    push(16'h7002, 1'b1, st);
    push(16'h7003, 1'b1, st);
    push(16'h7004, 1'b1, st);
    repeat (10) @(negedge clk_i);
    chk("pre_reset_count", 32'(count_o), 32'd3);
    chk("pre_reset_busy", 32'(busy_o), 32'd1);
    #2 rstn_i = 1'b0;
    x_q.delete();
    exp_q.delete();
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rstn_i = 1'b1;
    repeat (60) @(negedge clk_i);
    chk("post_reset_count", 32'(count_o), 32'd0);
    chk("post_reset_valid", 32'(m_valid_o), 32'd0);
    chk("post_reset_busy", 32'(busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
